// File: rtl/screen_sequencer_pkg.sv
// screen_sequencer_pkg: shared screen IDs, frame sizes and sequencer state type
package screen_sequencer_pkg;
  localparam int DEF_NUM_PIXELS = 76800;
  localparam int DEF_ADDR_W = 17;
  localparam logic [31:0] DEF_CLEAR_COLOR = 32'h0;
  localparam int DEF_HOLD_CYCLES = 4;
  localparam logic [1:0] SCR_MENU = 2'd0;
  localparam logic [1:0] SCR_GAME = 2'd1;
  localparam logic [1:0] SCR_OVER = 2'd2;
  localparam logic [1:0] SCR_CLEAR = 2'd3;
  typedef enum logic [2:0] {ST_CLEAR, ST_HOLD, ST_MENU, ST_GAME, ST_OVER} state_t;
  function automatic logic [1:0] screen_of(input state_t s);
    return s == ST_MENU ? SCR_MENU : s == ST_GAME ? SCR_GAME : s == ST_OVER ? SCR_OVER : SCR_CLEAR;
  endfunction
endpackage

// File: rtl/screen_sequencer_fb_clear_engine.sv
// fb_clear_engine: sweeps every framebuffer address once with the clear colour
module fb_clear_engine #(
  parameter int NUM_PIXELS = 76800,
  parameter int ADDR_W = 17,
  parameter logic [31:0] CLEAR_COLOR = 32'h0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_addr,
  output logic [31:0]       o_wdata,
  output logic              o_done
);
  logic              r_busy;
  logic [ADDR_W-1:0] r_cnt;
  always_ff @(posedge i_clk)
    if (i_reset || i_start) begin
      r_busy <= 1'b1;
      r_cnt <= '0;
    end else if (o_done) begin
      r_busy <= 1'b0;
      r_cnt <= '0;
    end else if (r_busy) begin
      r_cnt <= r_cnt + 1'b1;
    end
  assign o_we = r_busy;
  assign o_addr = r_cnt;
  assign o_wdata = CLEAR_COLOR;
  assign o_done = r_busy && r_cnt == ADDR_W'(NUM_PIXELS - 1);
endmodule

// File: rtl/screen_sequencer.sv
// screen_sequencer: sequences menu/game/over producers onto one framebuffer port with clears between screens
module screen_sequencer
  import screen_sequencer_pkg::*;
#(
  parameter int NUM_PIXELS = DEF_NUM_PIXELS,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter logic [31:0] CLEAR_COLOR = DEF_CLEAR_COLOR,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_menu_we,
  input  logic [ADDR_W-1:0] i_menu_addr,
  input  logic [31:0]       i_menu_wdata,
  input  logic              i_menu_done,
  input  logic              i_game_we,
  input  logic [ADDR_W-1:0] i_game_addr,
  input  logic [31:0]       i_game_wdata,
  input  logic              i_game_done,
  input  logic              i_game_won,
  input  logic              i_over_we,
  input  logic [ADDR_W-1:0] i_over_addr,
  input  logic [31:0]       i_over_wdata,
  input  logic              i_over_done,
  output logic              o_menu_rst_n,
  output logic              o_game_rst_n,
  output logic              o_over_rst_n,
  output logic              o_fb_we,
  output logic [ADDR_W-1:0] o_fb_addr,
  output logic [31:0]       o_fb_wdata,
  output logic [1:0]        o_cur_screen
);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  state_t              r_state, w_next, r_target, w_next_target;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic                w_leave, w_we, w_clr_we, w_clr_done;
  logic [ADDR_W-1:0]   w_addr, w_clr_addr;
  logic [31:0]         w_wdata, w_clr_wdata;
  fb_clear_engine #(
    .NUM_PIXELS (NUM_PIXELS),
    .ADDR_W     (ADDR_W),
    .CLEAR_COLOR(CLEAR_COLOR)
  ) u_clear (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_start(w_leave),
    .o_we   (w_clr_we),
    .o_addr (w_clr_addr),
    .o_wdata(w_clr_wdata),
    .o_done (w_clr_done)
  );
  always_comb begin
    w_next = r_state;
    w_next_target = r_target;
    w_leave = 1'b0;
    w_we = 1'b0;
    w_addr = '0;
    w_wdata = '0;
    case (r_state)
      ST_CLEAR: begin
        w_we = w_clr_we;
        w_addr = w_clr_addr;
        w_wdata = w_clr_wdata;
        w_next = w_clr_done ? ST_HOLD : ST_CLEAR;
      end
      ST_HOLD: w_next = r_hold_cnt == HOLD_W'(HOLD_CYCLES - 1) ? r_target : ST_HOLD;
      ST_MENU: begin
        w_we = i_menu_we;
        w_addr = i_menu_addr;
        w_wdata = i_menu_wdata;
        w_leave = i_menu_done && o_menu_rst_n;
        w_next_target = w_leave ? ST_GAME : r_target;
      end
      ST_GAME: begin
        w_we = i_game_we;
        w_addr = i_game_addr;
        w_wdata = i_game_wdata;
        w_leave = i_game_done && o_game_rst_n;
        w_next_target = w_leave ? (i_game_won ? ST_MENU : ST_OVER) : r_target;
      end
      ST_OVER: begin
        w_we = i_over_we;
        w_addr = i_over_addr;
        w_wdata = i_over_wdata;
        w_leave = i_over_done && o_over_rst_n;
        w_next_target = w_leave ? ST_MENU : r_target;
      end
      default: w_next = ST_CLEAR;
    endcase
    if (w_leave) w_next = ST_CLEAR;
  end
  always_ff @(posedge i_clk)
    if (i_reset) begin
      r_state <= ST_CLEAR;
      r_target <= ST_MENU;
      r_hold_cnt <= '0;
      o_fb_we <= 1'b0;
      o_fb_addr <= '0;
      o_fb_wdata <= '0;
      o_menu_rst_n <= 1'b0;
      o_game_rst_n <= 1'b0;
      o_over_rst_n <= 1'b0;
      o_cur_screen <= SCR_CLEAR;
    end else begin
      r_state <= w_next;
      r_target <= w_next_target;
      r_hold_cnt <= (r_state == ST_HOLD && w_next == ST_HOLD) ? r_hold_cnt + 1'b1 : '0;
      o_fb_we <= w_we;
      o_fb_addr <= w_addr;
      o_fb_wdata <= w_wdata;
      o_menu_rst_n <= w_next == ST_MENU;
      o_game_rst_n <= w_next == ST_GAME;
      o_over_rst_n <= w_next == ST_OVER;
      o_cur_screen <= screen_of(w_next);
    end
endmodule

// File: tb/tb_screen_sequencer.sv
// tb_screen_sequencer: scoreboarded random test of screen_sequencer against a screen-level model
`timescale 1ns/1ps
module tb_screen_sequencer;
  localparam int AW = 17;
  localparam int HOLD = 4;
  localparam int NP_FULL = 76800;
  localparam int NP_SMALL = 64;
  typedef struct packed {logic [AW-1:0] addr; logic [31:0] data;} wr_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst [2];
  logic m_we [2], g_we [2], ov_we [2], m_done [2], g_done [2], ov_done [2], g_won [2];
  logic [AW-1:0] m_addr [2], g_addr [2], ov_addr [2];
  logic [31:0] m_data [2], g_data [2], ov_data [2];
  logic m_rn [2], g_rn [2], ov_rn [2], fb_we [2];
  logic [AW-1:0] fb_addr [2];
  logic [31:0] fb_wdata [2];
  logic [1:0] cur [2];
  screen_sequencer #(.NUM_PIXELS(NP_FULL), .ADDR_W(AW), .CLEAR_COLOR(32'h0), .HOLD_CYCLES(HOLD)) u_full (
    .i_clk(clk), .i_reset(rst[0]),
    .i_menu_we(m_we[0]), .i_menu_addr(m_addr[0]), .i_menu_wdata(m_data[0]), .i_menu_done(m_done[0]),
    .i_game_we(g_we[0]), .i_game_addr(g_addr[0]), .i_game_wdata(g_data[0]), .i_game_done(g_done[0]),
    .i_game_won(g_won[0]),
    .i_over_we(ov_we[0]), .i_over_addr(ov_addr[0]), .i_over_wdata(ov_data[0]), .i_over_done(ov_done[0]),
    .o_menu_rst_n(m_rn[0]), .o_game_rst_n(g_rn[0]), .o_over_rst_n(ov_rn[0]),
    .o_fb_we(fb_we[0]), .o_fb_addr(fb_addr[0]), .o_fb_wdata(fb_wdata[0]), .o_cur_screen(cur[0]));
  screen_sequencer #(.NUM_PIXELS(NP_SMALL), .ADDR_W(AW), .CLEAR_COLOR(32'h0), .HOLD_CYCLES(HOLD)) u_small (
    .i_clk(clk), .i_reset(rst[1]),
    .i_menu_we(m_we[1]), .i_menu_addr(m_addr[1]), .i_menu_wdata(m_data[1]), .i_menu_done(m_done[1]),
    .i_game_we(g_we[1]), .i_game_addr(g_addr[1]), .i_game_wdata(g_data[1]), .i_game_done(g_done[1]),
    .i_game_won(g_won[1]),
    .i_over_we(ov_we[1]), .i_over_addr(ov_addr[1]), .i_over_wdata(ov_data[1]), .i_over_done(ov_done[1]),
    .o_menu_rst_n(m_rn[1]), .o_game_rst_n(g_rn[1]), .o_over_rst_n(ov_rn[1]),
    .o_fb_we(fb_we[1]), .o_fb_addr(fb_addr[1]), .o_fb_wdata(fb_wdata[1]), .o_cur_screen(cur[1]));
  int id = 0;
  int np = NP_FULL;
  int at = 0;
  int checks = 0;
  int passes = 0;
  wr_t exp_wr [$];
  logic [1:0] exp_scr [$];
  logic [1:0] mscr = 2'd3;
  logic [1:0] prev_cur = 2'd3;
  int gap = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask
  always @(negedge clk) begin
    if (!rst[id]) begin
      if (fb_we[id]) begin
        if (exp_wr.size() == 0) begin
          checks++;
          $display("FAIL fb_write: got addr %0h data %0h, expected no write", fb_addr[id], fb_wdata[id]);
        end else chk("fb_write", 64'({fb_addr[id], fb_wdata[id]}), 64'(exp_wr.pop_front()));
        gap = 0;
      end else gap++;
      if (cur[id] != prev_cur) begin
        if (exp_scr.size() == 0) begin
          checks++;
          $display("FAIL cur_screen: got %0d, expected no screen change", cur[id]);
        end else begin
          mscr = exp_scr.pop_front();
          chk("cur_screen", 64'(cur[id]), 64'(mscr));
          if (mscr != 2'd3) chk("hold_gap", 64'(gap), 64'(HOLD));
        end
      end
      chk("rst_n", 64'({ov_rn[id], g_rn[id], m_rn[id]}), mscr == 2'd3 ? 64'd0 : 64'd1 << mscr);
    end
    prev_cur = cur[id];
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic zero_inputs();
    {m_we[id], g_we[id], ov_we[id], m_done[id], g_done[id], ov_done[id], g_won[id]} = '0;
    {m_addr[id], g_addr[id], ov_addr[id]} = '0;
    {m_data[id], g_data[id], ov_data[id]} = '0;
  endtask
  task automatic drive();
    m_we[id] = 1'($urandom);
    g_we[id] = 1'($urandom);
    ov_we[id] = 1'($urandom);
    m_addr[id] = AW'($urandom);
    g_addr[id] = AW'($urandom);
    ov_addr[id] = AW'($urandom);
    m_data[id] = $urandom;
    g_data[id] = $urandom;
    ov_data[id] = $urandom;
    m_done[id] = $urandom_range(0, 3) == 0;
    g_done[id] = $urandom_range(0, 3) == 0;
    ov_done[id] = $urandom_range(0, 3) == 0;
    g_won[id] = 1'($urandom);
  endtask
  task automatic set_active(input logic done, input logic force_we);
    case (at)
      0: begin m_done[id] = done; if (force_we) m_we[id] = 1'b1; end
      1: begin g_done[id] = done; if (force_we) g_we[id] = 1'b1; end
      default: begin ov_done[id] = done; if (force_we) ov_we[id] = 1'b1; end
    endcase
  endtask
  task automatic push_active();
    case (at)
      0: if (m_we[id]) exp_wr.push_back(wr_t'({m_addr[id], m_data[id]}));
      1: if (g_we[id]) exp_wr.push_back(wr_t'({g_addr[id], g_data[id]}));
      default: if (ov_we[id]) exp_wr.push_back(wr_t'({ov_addr[id], ov_data[id]}));
    endcase
  endtask
  task automatic push_clear();
    for (int i = 0; i < np; i++) exp_wr.push_back(wr_t'({AW'(i), 32'h0}));
  endtask
  task automatic do_reset();
    rst[id] = 1'b1;
    drive();
    tick();
    chk("reset_fb_we", 64'(fb_we[id]), 64'd0);
    chk("reset_fb_addr", 64'(fb_addr[id]), 64'd0);
    chk("reset_fb_wdata", 64'(fb_wdata[id]), 64'd0);
    chk("reset_rst_n", 64'({ov_rn[id], g_rn[id], m_rn[id]}), 64'd0);
    chk("reset_cur_screen", 64'(cur[id]), 64'd3);
    exp_wr.delete();
    exp_scr.delete();
    mscr = 2'd3;
    push_clear();
    exp_scr.push_back(2'd0);
    at = 0;
    rst[id] = 1'b0;
  endtask
  task automatic wait_screen(input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      tick();
      if (cur[id] == 2'(at)) break;
      drive();
    end
    if (k == budget) begin
      checks++;
      $display("FAIL wait_screen: cur_screen %0d, expected %0d within %0d cycles", cur[id], at, budget);
    end
  endtask
  task automatic run_screen(input int n, input int won);
    int nxt;
    for (int c = 0; c < n; c++) begin
      drive();
      set_active(1'b0, 1'b0);
      push_active();
      tick();
    end
    drive();
    set_active(1'b1, 1'b1);
    if (won >= 0) g_won[id] = won[0];
    push_active();
    nxt = at == 0 ? 1 : at == 1 ? (g_won[id] ? 0 : 2) : 0;
    tick();
    push_clear();
    exp_scr.push_back(2'd3);
    exp_scr.push_back(2'(nxt));
    at = nxt;
  endtask
  task automatic reset_mid_clear(input int addr);
    int k;
    for (k = 0; k < 300; k++) begin
      tick();
      if (fb_we[id] && fb_addr[id] == AW'(addr) && fb_wdata[id] == 32'h0 && cur[id] == 2'd3) break;
      drive();
    end
    if (k == 300) begin
      checks++;
      $display("FAIL mid_clear_wait: clear address %0d not reached, last addr %0d", addr, fb_addr[id]);
    end
    do_reset();
  endtask
  initial begin
    rst[0] = 1'b1;
    rst[1] = 1'b1;
    id = 1;
    zero_inputs();
    id = 0;
    zero_inputs();
    np = NP_FULL;
    do_reset();
    wait_screen(NP_FULL + HOLD + 20);
    chk("full_menu_rst_n", 64'(m_rn[0]), 64'd1);
    zero_inputs();
    m_we[0] = 1'b1;
    m_addr[0] = AW'(5);
    m_data[0] = 32'hABC;
    g_we[0] = 1'b1;
    g_addr[0] = AW'(9);
    g_data[0] = 32'h123;
    exp_wr.push_back(wr_t'({AW'(5), 32'hABC}));
    tick();
    zero_inputs();
    chk("menu_fwd_addr", 64'(fb_addr[0]), 64'd5);
    chk("menu_fwd_data", 64'(fb_wdata[0]), 64'hABC);
    tick();
    chk("menu_fwd_we_drop", 64'(fb_we[0]), 64'd0);
    tick();
    chk("full_drained", 64'(exp_wr.size()), 64'd0);
    rst[0] = 1'b1;
    tick();
    id = 1;
    np = NP_SMALL;
    do_reset();
    wait_screen(200);
    run_screen(5, -1);
    wait_screen(200);
    run_screen(8, 0);
    wait_screen(200);
    run_screen(6, -1);
    wait_screen(200);
    run_screen(3, -1);
    wait_screen(200);
    run_screen(4, 1);
    wait_screen(200);
    run_screen(2, -1);
    reset_mid_clear(40);
    wait_screen(200);
    for (int r = 0; r < 40; r++) begin
      run_screen($urandom_range(0, 25), -1);
      wait_screen(200);
    end
    zero_inputs();
    repeat (4) tick();
    chk("small_wr_drained", 64'(exp_wr.size()), 64'd0);
    chk("small_scr_drained", 64'(exp_scr.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
